// File: rtl/ccff_bitstream_loader_if.sv
// Host-side word bus into the configuration-chain loader.
// The host drives the word and its valid; the loader returns ready.
interface ccff_bitstream_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (output cfg_data, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain driver: serializes host words MSB first onto ccff_head, qualified by ccff_shift_en.
// Optional CCFF_TAIL_CHECK_EN: after a full load, compare ccff_tail against the first bit shifted.
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 2048,
    parameter int WORD_W    = 8
) (
    input  logic                   prog_clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    ccff_bitstream_loader_if.slave cfg,
    output logic                   ccff_head,
    output logic                   ccff_shift_en,
    input  logic                   ccff_tail,
    output logic                   busy,
    output logic                   done,
    output logic                   chk_err
);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int WW = $clog2(WORD_W + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CHAIN_LEN);
    localparam logic [CW-1:0] BIT_ONE   = CW'(1);
    localparam logic [WW-1:0] WBIT_FULL = WW'(WORD_W);
    localparam logic [WW-1:0] WBIT_ONE  = WW'(1);

    // states: IDLE wait start | FETCH want a word | SHIFT head bit valid | DONE one-cycle done
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [WW-1:0]     wbit_q, wbit_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              head_q, head_d;
    logic              shift_en_q, shift_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ready;

`ifdef CCFF_TAIL_CHECK_EN
    logic              chk_err_q, chk_err_d;
    logic              first_bit_q, first_bit_d;
`endif

    // Registered head/shift_en describe the bit on the wire this cycle, so bit_cnt/wbit
    // already include that bit; the chain captures it on the closing edge.
    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        wbit_d     = wbit_q;
        bit_cnt_d  = bit_cnt_q;
        head_d     = head_q;
        shift_en_d = 1'b0;
        done_d     = 1'b0;
        ready      = 1'b0;
`ifdef CCFF_TAIL_CHECK_EN
        chk_err_d   = chk_err_q;
        first_bit_d = first_bit_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d   = ST_FETCH;
                    bit_cnt_d = '0;
`ifdef CCFF_TAIL_CHECK_EN
                    chk_err_d = 1'b0;
`endif
                end
            end
            ST_FETCH: ready = 1'b1;
            ST_SHIFT: begin
                if (bit_cnt_q == BIT_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (wbit_q == WBIT_ONE) begin
                    ready = 1'b1;
                    if (!cfg.cfg_valid) state_d = ST_FETCH;
                end else begin
                    head_d     = sreg_q[WORD_W-1];
                    sreg_d     = sreg_q << 1;
                    wbit_d     = wbit_q - WBIT_ONE;
                    bit_cnt_d  = bit_cnt_q + BIT_ONE;
                    shift_en_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
`ifdef CCFF_TAIL_CHECK_EN
                if (ccff_tail != first_bit_q) chk_err_d = 1'b1;
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort && state_q != ST_IDLE) begin
            state_d    = ST_IDLE;
            ready      = 1'b0;
            shift_en_d = 1'b0;
            done_d     = 1'b0;
`ifdef CCFF_TAIL_CHECK_EN
            chk_err_d  = chk_err_q;
`endif
        end

        if (ready && cfg.cfg_valid) begin
            state_d    = ST_SHIFT;
            head_d     = cfg.cfg_data[WORD_W-1];
            sreg_d     = cfg.cfg_data << 1;
            wbit_d     = WBIT_FULL;
            bit_cnt_d  = bit_cnt_q + BIT_ONE;
            shift_en_d = 1'b1;
`ifdef CCFF_TAIL_CHECK_EN
            if (bit_cnt_q == '0) first_bit_d = cfg.cfg_data[WORD_W-1];
`endif
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge prog_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            sreg_q     <= '0;
            wbit_q     <= '0;
            bit_cnt_q  <= '0;
            head_q     <= 1'b0;
            shift_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            wbit_q     <= wbit_d;
            bit_cnt_q  <= bit_cnt_d;
            head_q     <= head_d;
            shift_en_q <= shift_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef CCFF_TAIL_CHECK_EN
    always_ff @(posedge prog_clk or negedge reset_n) begin
        if (!reset_n) begin
            chk_err_q   <= 1'b0;
            first_bit_q <= 1'b0;
        end else begin
            chk_err_q   <= chk_err_d;
            first_bit_q <= first_bit_d;
        end
    end

    assign chk_err = chk_err_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign chk_err     = 1'b0;
`endif

    assign cfg.cfg_ready = ready;
    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: three instances (20/8/1-bit chains) driven by directed word lists,
// a word-list bit model checked every shift, and modelled chains feeding ccff_tail.
module tb_ccff_bitstream_loader;
    localparam int W = 8;
`ifdef CCFF_TAIL_CHECK_EN
    localparam logic TAIL_CHK = 1'b1;
`else
    localparam logic TAIL_CHK = 1'b0;
`endif

    logic         prog_clk = 1'b0;
    logic         reset_n  = 1'b0;
    logic         abort    = 1'b0;
    logic [2:0]   start_v  = '0;
    logic [W-1:0] drv_data = '0;
    logic         drv_valid = 1'b0;
    logic [2:0]   head_v, sh_v, busy_v, done_v, err_v, tail_v, rdy_v;

    logic [19:0]  chain_a = '0;
    logic [7:0]   chain_b = '0;
    logic         chain_c = 1'b0;
    int           tail_tap = 19;

    always #5 prog_clk = ~prog_clk;

    ccff_bitstream_loader_if #(.WORD_W(W)) if20 ();
    ccff_bitstream_loader_if #(.WORD_W(W)) if8 ();
    ccff_bitstream_loader_if #(.WORD_W(W)) if1 ();

    assign if20.cfg_data = drv_data;  assign if20.cfg_valid = drv_valid;  assign rdy_v[0] = if20.cfg_ready;
    assign if8.cfg_data  = drv_data;  assign if8.cfg_valid  = drv_valid;  assign rdy_v[1] = if8.cfg_ready;
    assign if1.cfg_data  = drv_data;  assign if1.cfg_valid  = drv_valid;  assign rdy_v[2] = if1.cfg_ready;

    assign tail_v[0] = chain_a[tail_tap];
    assign tail_v[1] = chain_b[7];
    assign tail_v[2] = chain_c;

    ccff_bitstream_loader #(.CHAIN_LEN(20), .WORD_W(W)) u20 (
        .prog_clk(prog_clk), .reset_n(reset_n), .start(start_v[0]), .abort(abort), .cfg(if20),
        .ccff_head(head_v[0]), .ccff_shift_en(sh_v[0]), .ccff_tail(tail_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .chk_err(err_v[0]));
    ccff_bitstream_loader #(.CHAIN_LEN(8), .WORD_W(W)) u8 (
        .prog_clk(prog_clk), .reset_n(reset_n), .start(start_v[1]), .abort(abort), .cfg(if8),
        .ccff_head(head_v[1]), .ccff_shift_en(sh_v[1]), .ccff_tail(tail_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .chk_err(err_v[1]));
    ccff_bitstream_loader #(.CHAIN_LEN(1), .WORD_W(W)) u1 (
        .prog_clk(prog_clk), .reset_n(reset_n), .start(start_v[2]), .abort(abort), .cfg(if1),
        .ccff_head(head_v[2]), .ccff_shift_en(sh_v[2]), .ccff_tail(tail_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .chk_err(err_v[2]));

    // The physical chains: capture head on every edge where shift_en is high.
    always @(posedge prog_clk) begin
        if (sh_v[0]) chain_a <= {chain_a[18:0], head_v[0]};
        if (sh_v[1]) chain_b <= {chain_b[6:0], head_v[1]};
        if (sh_v[2]) chain_c <= head_v[2];
    end

    int           compared   = 0;
    int           mismatched = 0;
    int           act = 0, chain_len = 20, n_exp_words = 3;
    int           shcnt = 0, wcnt = 0, dcnt = 0, first_sh = -1, last_sh = -1, cyc = 0;
    logic [31:0]  head_seq = '0;
    bit           mon_on = 1'b0;
    logic [W-1:0] words [0:7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Bit i of the load is bit (W-1 - i%W) of word i/W.
    function automatic logic model_bit(input int i);
        logic [W-1:0] w;
        w = words[i / W];
        return w[W-1 - (i % W)];
    endfunction

    function automatic logic [5:0] outs(input int k);
        return {rdy_v[k], head_v[k], sh_v[k], busy_v[k], done_v[k], err_v[k]};
    endfunction

    always @(negedge prog_clk) begin
        cyc++;
        if (mon_on) begin
            if (sh_v[act]) begin
                check("shift_in_range", 32'(shcnt < chain_len), 1);
                if (shcnt < chain_len) check("head_bit", 32'(head_v[act]), 32'(model_bit(shcnt)));
                head_seq = {head_seq[30:0], head_v[act]};
                if (first_sh < 0) first_sh = cyc;
                last_sh = cyc;
                shcnt++;
            end
            if (rdy_v[act]) begin
                check("no_extra_word", 32'(wcnt < n_exp_words), 1);
                if (drv_valid) wcnt++;
            end
            if (done_v[act]) begin
                dcnt++;
                check("done_after_all_shifts", shcnt, chain_len);
                check("busy_with_done", 32'(busy_v[act]), 1);
                check("done_without_shift", 32'(sh_v[act]), 0);
            end
        end
    end

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge prog_clk);
        #1;
    endtask

    task automatic arm(input int k, input int len, input int nw);
        act = k; chain_len = len; n_exp_words = nw;
        shcnt = 0; wcnt = 0; dcnt = 0; first_sh = -1; last_sh = -1; head_seq = '0;
        mon_on = 1'b1;
    endtask

    // Drive one load on instance k. gap: ready-but-not-valid cycles inserted after each word;
    // abort_at: shift count after which abort is raised (0 = never); restart_at: loop cycle to re-pulse start.
    task automatic run_load(input int k, input int gap, input int abort_at, input int restart_at);
        int ptr, stall;
        bit xf, st, aborted, finished;
        ptr = 0; stall = 0; aborted = 1'b0; finished = 1'b0;
        drv_data = words[0]; drv_valid = 1'b1;
        start_v[k] = 1'b1;
        tick();
        start_v[k] = 1'b0;
        for (int n = 0; n < 300 && !finished; n++) begin
            sample();
            if (abort) check("abort_ready_low", 32'(rdy_v[k]), 0);
            if (aborted && !abort) begin
                check("abort_shift_en", 32'(sh_v[k]), 0);
                check("abort_busy", 32'(busy_v[k]), 0);
                check("abort_ready", 32'(rdy_v[k]), 0);
                finished = 1'b1;
            end
            if (done_v[k]) finished = 1'b1;
            xf = rdy_v[k] & drv_valid;
            st = rdy_v[k] & !drv_valid;
            tick();
            start_v[k] = (n == restart_at);
            abort = 1'b0;
            if (abort_at != 0 && !aborted && shcnt == abort_at) begin
                abort = 1'b1;
                aborted = 1'b1;
            end
            if (xf) begin
                ptr++;
                drv_data = words[ptr];
                if (gap > 0) begin
                    drv_valid = 1'b0;
                    stall = 0;
                end
            end else if (!drv_valid && st) begin
                stall++;
                if (stall == gap) drv_valid = 1'b1;
            end
        end
        start_v[k] = 1'b0;
        abort = 1'b0;
        check("load_finished", 32'(finished), 1);
    endtask

    task automatic settle(input int k, input int exp_done);
        repeat (3) tick();
        sample();
        check("idle_busy", 32'(busy_v[k]), 0);
        check("idle_done", 32'(done_v[k]), 0);
        check("done_pulses", dcnt, exp_done);
    endtask

    task automatic load_abc();
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hF7; words[3] = 8'h66; words[4] = 8'h99;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) words[i] = '0;
        load_abc();
        #2;
        for (int k = 0; k < 3; k++) check("reset_outputs", 32'(outs(k)), 0);
        tick(); tick();
        #3 reset_n = 1'b1;
        tick();

        // Basic load: 20 bits, words held valid, no bubbles.
        arm(0, 20, 3);
        run_load(0, 0, 0, -1);
        check("basic_shifts", shcnt, 20);
        check("basic_words", wcnt, 3);
        check("basic_span", last_sh - first_sh, 19);
        check("basic_head_seq", head_seq[19:0], 20'hA53CF);
        check("basic_chain", chain_a, 20'hA53CF);
        settle(0, 1);
        check("basic_chk_err", 32'(err_v[0]), 0);

        // Backpressure: three stalled cycles at each of the two word boundaries.
        arm(0, 20, 3);
        run_load(0, 3, 0, -1);
        check("bp_shifts", shcnt, 20);
        check("bp_words", wcnt, 3);
        check("bp_span", last_sh - first_sh, 25);
        check("bp_head_seq", head_seq[19:0], 20'hA53CF);
        settle(0, 1);

        // Abort after the 10th shift, then a full load.
        arm(0, 20, 3);
        run_load(0, 0, 10, -1);
        settle(0, 0);
        arm(0, 20, 3);
        run_load(0, 0, 0, -1);
        check("post_abort_shifts", shcnt, 20);
        check("post_abort_head_seq", head_seq[19:0], 20'hA53CF);
        check("post_abort_chain", chain_a, 20'hA53CF);
        settle(0, 1);

        // Tail tapped one flop short: tail holds the second bit (0) instead of the first (1).
        tail_tap = 18;
        arm(0, 20, 3);
        run_load(0, 0, 0, -1);
        settle(0, 1);
        check("short_chain_chk_err", 32'(err_v[0]), 32'(TAIL_CHK));
        repeat (2) tick();
        sample();
        check("chk_err_sticky", 32'(err_v[0]), 32'(TAIL_CHK));
        tail_tap = 19;
        arm(0, 20, 3);
        run_load(0, 0, 0, -1);
        settle(0, 1);
        check("full_chain_chk_err", 32'(err_v[0]), 0);

        // Asynchronous reset mid-word; start held during reset must be ignored.
        arm(0, 20, 3);
        drv_data = words[0]; drv_valid = 1'b1;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        for (int n = 0; n < 40 && shcnt < 4; n++) sample();
        check("reset_reached_mid_word", shcnt, 4);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'(outs(0)), 0);
        start_v[0] = 1'b1;
        tick(); tick();
        start_v[0] = 1'b0;
        check("in_reset_busy", 32'(busy_v[0]), 0);
        #2 reset_n = 1'b1;
        tick(); tick();
        sample();
        check("after_reset_outputs", 32'({rdy_v[0], sh_v[0], busy_v[0], done_v[0]}), 0);

        // Boundary: one-word chain, start re-pulsed mid-load.
        words[0] = 8'h5A; words[1] = 8'hC3; words[2] = 8'h0F;
        arm(1, 8, 1);
        run_load(1, 0, 0, 3);
        check("w8_shifts", shcnt, 8);
        check("w8_words", wcnt, 1);
        check("w8_head_seq", head_seq[7:0], 8'h5A);
        check("w8_chain", chain_b, 8'h5A);
        settle(1, 1);
        check("w8_chk_err", 32'(err_v[1]), 0);

        // Boundary: single-flop chain, low seven bits of the word discarded.
        words[0] = 8'hB2; words[1] = 8'h44; words[2] = 8'h11;
        arm(2, 1, 1);
        run_load(2, 0, 0, 0);
        check("w1_shifts", shcnt, 1);
        check("w1_words", wcnt, 1);
        check("w1_head_seq", head_seq[0], 1);
        settle(2, 1);
        check("w1_chk_err", 32'(err_v[2]), 0);

        mon_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
